wnaf_recoder: RTL and testbench

Parametrised width-w NAF scalar recoder feeding the SM2 point-multiplication datapath. Accepts a KW-bit unsigned scalar, recodes it one digit per cycle into an internal digit buffer, then streams the signed odd digits MSB-first over a valid/ready handshake together with the digit count. It generalises the fixed NAF scalar/length pair of the current point multiplier to any window width and scalar width, and adds back-pressure plus an explicit end-of-stream marker.

---
 rtl/sm2_pkg.sv | 23 ++
 rtl/wnaf_digit.sv | 35 +++
 rtl/wnaf_recoder.sv | 112 +++++++++++
 tb/tb_wnaf_recoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm2_pkg.sv
// sm2_pkg: constants and types shared by the SM2 point-multiplication front end.
//   SM2_KW        default scalar width in bits
//   SM2_W_DEF     default wNAF window width (2 = plain NAF)
//   SM2_W_MAX     widest window the recoder accepts
//   digit_t       signed digit at the default window width; blocks built for a
//                 different W declare logic signed [W-1:0] with the same layout
//   wnaf_state_t  recoder FSM encoding, also exported on the debug port
package sm2_pkg;

    localparam int SM2_KW    = 256;
    localparam int SM2_W_DEF = 2;
    localparam int SM2_W_MAX = 8;

    typedef logic signed [SM2_W_DEF-1:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECODE = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } wnaf_state_t;

endpackage

// File: rtl/wnaf_digit.sv
// wnaf_digit: one combinational wNAF recoding step.
//   k       in   KW+1  remaining (non-negative) scalar
//   d       out  W     signed digit produced for the current bit position
//   k_next  out  KW+1  (k - d) >> 1, the scalar left for the next position
// Kept free of state so an on-the-fly recoder can reuse it directly.
module wnaf_digit
    import sm2_pkg::*;
#(
    parameter int KW = SM2_KW,
    parameter int W  = SM2_W_DEF
) (
    input  logic [KW:0]  k,
    output logic [W-1:0] d,
    output logic [KW:0]  k_next
);

    logic [KW:0] d_ext;
    logic [KW:0] diff;

    always_comb begin
        d     = '0;
        d_ext = '0;
        diff  = k;
        if (k[0]) begin
            // Reading the low W bits as two's complement yields r when
            // r < 2^(W-1) and r - 2^W otherwise, which is exactly the digit.
            d     = k[W-1:0];
            d_ext = {{(KW+1-W){k[W-1]}}, k[W-1:0]};
            // k - d is always >= 0 and < 2^(KW+1); its low W bits are zero.
            diff  = k - d_ext;
        end
        k_next = diff >> 1;
    end

endmodule

// File: rtl/wnaf_recoder.sv
// wnaf_recoder: width-W NAF recoder for a KW-bit unsigned scalar.
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start, k_in   job request and scalar, sampled only in IDLE
//   busy          high in every state except IDLE
//   nlen          digit count, held from the first dig_valid until the next start
//   dig_valid/dig_ready/dig/dig_last  MSB-first signed digit stream
//   done          one-cycle pulse when the job finishes
//   dbg_state     current FSM state
// Handshake: a digit transfers on a rising edge where dig_valid && dig_ready.
// Once dig_valid rises it stays high, with dig and dig_last stable, until that
// transfer happens; dig_ready may toggle freely and never affects dig_valid.
module wnaf_recoder
    import sm2_pkg::*;
#(
    parameter int KW = SM2_KW,
    parameter int W  = SM2_W_DEF,
    parameter int CW = $clog2(KW + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KW-1:0]     k_in,
    output logic              busy,
    output logic [CW-1:0]     nlen,
    output logic              dig_valid,
    input  logic              dig_ready,
    output logic [W-1:0]      dig,
    output logic              dig_last,
    output logic              done,
    output wnaf_state_t       dbg_state
);

    wnaf_state_t   state, state_nx;
    logic [KW:0]   k;
    logic [KW:0]   k_next;
    logic [W-1:0]  d;
    logic [CW-1:0] idx;
    logic [CW-1:0] ptr;
    logic [W-1:0]  dbuf [0:KW];

    wnaf_digit #(.KW(KW), .W(W)) u_digit (
        .k      (k),
        .d      (d),
        .k_next (k_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (start) state_nx = ST_RECODE;
            ST_RECODE: if (k == '0) state_nx = (idx != '0) ? ST_STREAM : ST_DONE;
            ST_STREAM: if (dig_ready && ptr == '0) state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k    <= '0;
            idx  <= '0;
            ptr  <= '0;
            nlen <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        k    <= {1'b0, k_in};
                        idx  <= '0;
                        nlen <= '0;
                    end
                end
                ST_RECODE: begin
                    if (k != '0) begin
                        k   <= k_next;
                        idx <= idx + CW'(1);
                    end else begin
                        nlen <= idx;
                        // Wraps when idx == 0, but that path goes to DONE
                        // and never reads ptr.
                        ptr  <= idx - CW'(1);
                    end
                end
                ST_STREAM: begin
                    if (dig_ready && ptr != '0) ptr <= ptr - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Digit storage carries no reset; every entry read in STREAM was
    // written during the same job's RECODE phase.
    always_ff @(posedge clk) begin
        if (state == ST_RECODE && k != '0) dbuf[idx] <= d;
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        dig_valid = (state == ST_STREAM);
        dig       = dig_valid ? dbuf[ptr] : '0;
        dig_last  = dig_valid && (ptr == '0);
        done      = (state == ST_DONE);
        dbg_state = state;
    end

endmodule

// File: tb/tb_wnaf_recoder.sv
// tb_wnaf_recoder: scoreboard bench for wnaf_recoder at KW=256, W=2..6.
module tb_wnaf_recoder;
    import sm2_pkg::*;

    localparam int KW = SM2_KW;
    localparam int CW = $clog2(KW + 2);
    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- comparison helpers ----------------
    task automatic check_eq(input int w, input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL w%0d %s: got %0d, expected %0d (cycle %0d)", w, name, act, req, cyc);
        end
    endtask

    task automatic check_wide(input int w, input string name, input logic [KW+2:0] act, input logic [KW+2:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL w%0d %s: got %0h, expected %0h", w, name, act, req);
        end
    endtask

    task automatic fail_now(input int w, input string name);
        n_checks++;
        n_errors++;
        $display("FAIL w%0d %s: event did not occur as required (cycle %0d)", w, name, cyc);
    endtask

    function automatic logic [KW-1:0] rnd_scalar();
        logic [KW-1:0] r;
        for (int i = 0; i < KW / 32; i++) r[i*32 +: 32] = $urandom;
        if ($urandom_range(0, 1) == 1) r = r >> $urandom_range(0, KW - 1);
        return r;
    endfunction

    // ---------------- one DUT per window width ----------------
    for (genvar gi = 0; gi < NI; gi++) begin : g
        localparam int WW = gi + 2;

        logic          start, rst_l, busy, dig_valid, dig_ready, dig_last, done;
        logic [KW-1:0] k_in;
        logic [CW-1:0] nlen;
        logic [WW-1:0] dig;
        wnaf_state_t   dbg;

        wnaf_recoder #(.KW(KW), .W(WW)) dut (
            .clk       (clk),
            .rst       (rst | rst_l),
            .start     (start),
            .k_in      (k_in),
            .busy      (busy),
            .nlen      (nlen),
            .dig_valid (dig_valid),
            .dig_ready (dig_ready),
            .dig       (dig),
            .dig_last  (dig_last),
            .done      (done),
            .dbg_state (dbg)
        );

        // scoreboard state
        logic [WW-1:0] exp_q[$];
        logic [WW-1:0] got_q[$];
        int            mdl[$];
        int            exp_nlen;
        bit            ready_full;
        bit            seen_first, stalled, fin;
        logic [WW-1:0] held_dig;
        logic          held_last;
        int            t_start, first_edge, done_edge, done_cnt, busy_cnt;

        // Reference: wNAF digits LSB-first, straight from the recoding rule.
        task automatic build_model(input logic [KW-1:0] k);
            logic signed [KW+1:0] kk;
            longint m;
            int dv;
            m = longint'(1) << WW;
            kk = {2'b00, k};
            mdl.delete();
            while (kk != 0) begin
                if (kk % 2 != 0) begin
                    dv = int'(kk % m);
                    if (dv >= m / 2) dv = dv - int'(m);
                    kk = kk - dv;
                end else begin
                    dv = 0;
                end
                mdl.push_back(dv);
                kk = kk / 2;
            end
        endtask

        task automatic prep_job(input logic [KW-1:0] k, input bit full);
            build_model(k);
            exp_q.delete();
            for (int i = mdl.size() - 1; i >= 0; i--) exp_q.push_back(WW'(mdl[i]));
            exp_nlen   = mdl.size();
            got_q.delete();
            seen_first = 0;
            stalled    = 0;
            done_cnt   = 0;
            busy_cnt   = 0;
            ready_full = full;
        endtask

        task automatic check_properties(input logic [KW-1:0] k);
            logic signed [KW+2:0] acc;
            int dv, bad, sparse, last_nz;
            acc = '0; bad = 0; sparse = 0; last_nz = -KW * 4;
            foreach (got_q[i]) begin
                dv  = $signed(got_q[i]);
                acc = acc * 2 + dv;
                if (dv != 0) begin
                    if ((dv % 2 == 0) || dv > (1 << (WW - 1)) - 1 || dv < -((1 << (WW - 1)) - 1)) bad++;
                    if (i - last_nz < WW) sparse++;
                    last_nz = i;
                end
            end
            check_wide(WW, "digit_sum", acc, {3'b000, k});
            check_eq(WW, "odd_bound_violations", bad, 0);
            check_eq(WW, "window_sparsity_violations", sparse, 0);
            if (got_q.size() > 0) check_eq(WW, "msd_nonzero", (got_q[0] != '0), 1);
        endtask

        task automatic run_job(input logic [KW-1:0] k, input bit full, input bit glitch);
            int len, guard;
            prep_job(k, full);
            len   = exp_nlen;
            start = 1'b1;
            k_in  = k;
            @(posedge clk); #1;
            start   = 1'b0;
            t_start = cyc;
            if (glitch && len > 0) begin
                start = 1'b1;
                k_in  = ~k;
                @(posedge clk); #1;
                start = 1'b0;
                guard = 0;
                while (!dig_valid && guard < 2000) begin @(posedge clk); #1; guard++; end
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                k_in  = k;
            end
            guard = 0;
            while (done_cnt == 0 && guard < 6000) begin @(posedge clk); guard++; end
            #1;
            if (done_cnt == 0) fail_now(WW, "done_timeout");
            check_eq(WW, "busy_after_done", busy, 0);
            check_eq(WW, "valid_after_done", dig_valid, 0);
            check_eq(WW, "done_width", done, 0);
            check_eq(WW, "nlen_after_done", nlen, len);
            check_eq(WW, "digits_left", exp_q.size(), 0);
            if (full) begin
                if (len > 0) check_eq(WW, "first_valid_latency", first_edge - t_start, len + 2);
                else         check_eq(WW, "zero_no_valid", seen_first, 0);
                check_eq(WW, "done_latency", done_edge - t_start, 2 * len + 2);
                check_eq(WW, "busy_cycles", busy_cnt, 2 * len + 2);
            end
            check_properties(k);
        endtask

        task automatic run_reset_job(input logic [KW-1:0] k);
            int guard;
            prep_job(k, 1'b1);
            start = 1'b1;
            k_in  = k;
            @(posedge clk); #1;
            start = 1'b0;
            guard = 0;
            while (!dig_valid && guard < 2000) begin @(posedge clk); #1; guard++; end
            if (!dig_valid) fail_now(WW, "reset_job_stream_start");
            @(posedge clk); #1;
            rst_l = 1'b1;
            @(posedge clk); #1;
            check_eq(WW, "midrst_busy", busy, 0);
            check_eq(WW, "midrst_valid", dig_valid, 0);
            check_eq(WW, "midrst_last", dig_last, 0);
            check_eq(WW, "midrst_done", done, 0);
            check_eq(WW, "midrst_nlen", nlen, 0);
            check_eq(WW, "midrst_dig", dig, 0);
            check_eq(WW, "midrst_state", dbg, ST_IDLE);
            rst_l = 1'b0;
            exp_q.delete();
            stalled = 0;
        endtask

        // ready driver
        initial begin
            dig_ready = 1'b1;
            forever begin
                @(posedge clk); #1;
                dig_ready = ready_full ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
        end

        // monitor: pops the expected queue on every handshake
        always @(negedge clk) begin
            logic [WW-1:0] e;
            if (!rst && !rst_l) begin
                if (busy) busy_cnt++;
                if (done) begin done_cnt++; done_edge = cyc + 1; end
                if (dig_valid) begin
                    if (!seen_first) begin
                        seen_first = 1;
                        first_edge = cyc + 1;
                        check_eq(WW, "nlen_at_stream", nlen, exp_nlen);
                    end
                    if (stalled) begin
                        check_eq(WW, "stall_dig", dig, held_dig);
                        check_eq(WW, "stall_last", dig_last, held_last);
                    end
                    if (dig_ready) begin
                        stalled = 0;
                        if (exp_q.size() == 0) begin
                            fail_now(WW, "unexpected_digit");
                        end else begin
                            e = exp_q.pop_front();
                            check_eq(WW, "dig", dig, e);
                            check_eq(WW, "dig_last", dig_last, (exp_q.size() == 0));
                            got_q.push_back(dig);
                        end
                    end else begin
                        stalled   = 1;
                        held_dig  = dig;
                        held_last = dig_last;
                    end
                end else if (stalled) begin
                    fail_now(WW, "valid_dropped_without_handshake");
                    stalled = 0;
                end
            end
        end

        // stimulus
        initial begin
            start = 1'b0; k_in = '0; rst_l = 1'b0; ready_full = 1'b1; fin = 1'b0;
            stalled = 0; seen_first = 0; done_cnt = 0; busy_cnt = 0;
            repeat (2) @(posedge clk); #1;
            check_eq(WW, "rst_busy", busy, 0);
            check_eq(WW, "rst_valid", dig_valid, 0);
            check_eq(WW, "rst_last", dig_last, 0);
            check_eq(WW, "rst_done", done, 0);
            check_eq(WW, "rst_nlen", nlen, 0);
            check_eq(WW, "rst_dig", dig, 0);
            repeat (4) @(posedge clk); #1;
            run_job(KW'(7), 1'b1, 1'b0);
            run_job(KW'(31), 1'b1, 1'b0);
            run_job('0, 1'b1, 1'b0);
            run_job('1, 1'b1, 1'b0);
            run_job(KW'(1) << (KW - 1), 1'b1, 1'b0);
            run_job(rnd_scalar() | KW'(64'hF0), 1'b0, 1'b1);
            run_reset_job(rnd_scalar() | (KW'(1) << (KW - 1)));
            run_job(rnd_scalar(), 1'b1, 1'b0);
            for (int j = 0; j < 8; j++) run_job(rnd_scalar(), (j % 3 == 0), 1'b0);
            fin = 1'b1;
        end
    end

    // ---------------- top-level sequencing / report ----------------
    initial begin
        rst = 1'b1;
        repeat (4) @(posedge clk); #1;
        rst = 1'b0;
        wait (g[0].fin && g[1].fin && g[2].fin && g[3].fin && g[4].fin);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #600000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: simulation still running at cycle %0d, limit 60000", cyc);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
